// File: rtl/lib_clk_gen.sv
// Lock-qualified reset generator with NUM_CH phase-accumulator clock-enable channels.
// Define CLKGEN_LOCK_MON_EN to build the sticky lock-loss monitor (lock_lost / lost_cnt).
module lib_clk_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_INIT = {1'b1, {(ACC_W-1){1'b0}}},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  output logic              rst_out,
  output logic [NUM_CH-1:0] ce,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              lost_clr,
  output logic              lock_lost,
  output logic [7:0]        lost_cnt
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_STAB, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic               rst_q;
  logic [NUM_CH-1:0]  ce_q;
  logic               run_stay;

  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic [ACC_W-1:0]   inc_q [NUM_CH];
  logic [ACC_W-1:0]   inc_d [NUM_CH];
  logic [NUM_CH-1:0]  carry;
  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  apply;

  logic               pend_valid_q;
  logic [CH_W-1:0]    pend_ch_q;
  logic [ACC_W-1:0]   pend_inc_q;
  logic               pend_clear;

  assign lock_s    = sync_q[1];
  assign rst_out   = rst_q;
  assign ce        = ce_q;
  assign cfg_ready = !pend_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STAB;
          cnt_d   = '0;
        end
      end
      ST_STAB: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Accumulate only while remaining in RUN, so ce drops on the exit edge.
  assign run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W:0] sum;
      assign sum       = {1'b0, acc_q[gi]} + {1'b0, inc_q[gi]};
      assign carry[gi] = run_stay & sum[ACC_W];
      assign acc_d[gi] = run_stay ? sum[ACC_W-1:0] : '0;
      assign hit[gi]   = (pend_ch_q == CH_W'(gi));
      // A zero increment would never carry, so it must not block the update.
      assign apply[gi] = pend_valid_q & hit[gi] &
                         ((state_q != ST_RUN) | (inc_q[gi] == '0) | carry[gi]);
      assign inc_d[gi] = apply[gi] ? pend_inc_q : inc_q[gi];
    end
  endgenerate

  assign pend_clear = pend_valid_q & ((~|hit) | (|apply));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      sync_q       <= '0;
      rst_q        <= 1'b1;
      ce_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_inc_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], locked};
      rst_q   <= (state_d != ST_RUN);
      ce_q    <= carry;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
      if (pend_clear) begin
        pend_valid_q <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
        pend_valid_q <= 1'b1;
        pend_ch_q    <= cfg_ch;
        pend_inc_q   <= cfg_inc;
      end
    end
  end

`ifdef CLKGEN_LOCK_MON_EN
  logic       lost_q;
  logic [7:0] lost_cnt_q;
  logic       loss_evt;

  assign loss_evt  = (state_q == ST_RUN) && (state_d != ST_RUN);
  assign lock_lost = lost_q;
  assign lost_cnt  = lost_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lost_q     <= 1'b0;
      lost_cnt_q <= '0;
    end else if (lost_clr) begin
      lost_q     <= 1'b0;
      lost_cnt_q <= '0;
    end else if (loss_evt) begin
      lost_q <= 1'b1;
      if (lost_cnt_q != 8'hFF) begin
        lost_cnt_q <= lost_cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_lost_clr;
  assign unused_lost_clr = lost_clr;
  assign lock_lost       = 1'b0;
  assign lost_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_lib_clk_gen.sv
// Randomised bench for lib_clk_gen against a lock-streak / phase-arithmetic reference model.
module tb_lib_clk_gen;
  localparam int NUM_CH = 3;
  localparam int ACC_W  = 8;
  localparam int LC     = 4;
  localparam int MOD    = 1 << ACC_W;
`ifdef CLKGEN_LOCK_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              locked;
  logic              rst_out;
  logic [NUM_CH-1:0] ce;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [7:0]        cfg_inc;
  logic              lost_clr;
  logic              lock_lost;
  logic [7:0]        lost_cnt;

  lib_clk_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LC)) dut (
    .clock(clock), .reset(reset), .locked(locked), .rst_out(rst_out), .ce(ce),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .lost_clr(lost_clr), .lock_lost(lock_lost), .lost_cnt(lost_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: RUN holds once the synchronised lock has been high LC+1 edges.
  int              m_inc [NUM_CH];
  int              m_phase [NUM_CH];
  int              st1, st2;
  bit              m_run;
  bit [NUM_CH-1:0] m_ce;
  bit              m_pend;
  int              m_pch, m_pinc;
  bit              m_accepted;
  bit              m_lost;
  int              m_lcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    st1 = 0; st2 = 0; m_run = 0; m_ce = '0; m_pend = 0;
    m_lost = 0; m_lcnt = 0; m_accepted = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_inc[i] = MOD / 2;
      m_phase[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int  s_k;
    int  p;
    bit  run_now;
    bit  run_prev;
    run_prev = m_run;
    s_k = locked ? st1 + 1 : 0;
    if (s_k > 1000) s_k = 1000;
    run_now = (st2 >= LC + 1);
    st2 = st1;
    st1 = s_k;
    m_accepted = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (run_prev && run_now) begin
        p = m_phase[i] + m_inc[i];
        m_ce[i] = (p >= MOD);
        m_phase[i] = p % MOD;
      end else begin
        m_ce[i] = 0;
        m_phase[i] = 0;
      end
    end
    if (m_pend) begin
      if (m_pch >= NUM_CH) begin
        m_pend = 0;
      end else if (!run_prev || m_inc[m_pch] == 0 || m_ce[m_pch]) begin
        m_inc[m_pch] = m_pinc;
        m_pend = 0;
      end
    end else if (cfg_valid) begin
      m_pend = 1;
      m_pch = int'(cfg_ch);
      m_pinc = int'(cfg_inc);
      m_accepted = 1;
    end
    if (MON) begin
      if (lost_clr) begin
        m_lost = 0;
        m_lcnt = 0;
      end else if (run_prev && !run_now) begin
        m_lost = 1;
        if (m_lcnt < 255) m_lcnt++;
      end
    end
    m_run = run_now;
  endfunction

  task automatic compare_all();
    chk("rst_out", rst_out, !m_run);
    chk("ce", ce, m_ce);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("lock_lost", lock_lost, m_lost);
    chk("lost_cnt", lost_cnt, m_lcnt);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    if (m_accepted) $display("cfg accepted ch=%0d inc=%0d t=%0t", m_pch, m_pinc, $time);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic cfg_send(input int ch, input int inc);
    int n;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_inc = 8'(inc);
    n = 0;
    do begin
      step();
      n++;
    end while (!m_accepted && n < 50);
    cfg_valid = 1'b0;
  endtask

  task automatic count_to_run(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (rst_out && n < 60);
  endtask

  task automatic count_to_ce(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ce[ch] && n < 60);
  endtask

  initial begin
    int n;
    reset = 1'b0; locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; lost_clr = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Channel 1 set to 64 while waiting for lock.
    cfg_send(1, 64);
    step();

    locked = 1'b1;
    count_to_run(n);
    chk("lock_edges", n, LC + 3);
    count_to_ce(0, n);
    chk("ce0_first", n, 2);
    count_to_ce(1, n);
    count_to_ce(1, n);
    chk("ce1_period", n, 4);

    // Slow channel 0 down; the update lands on a carry edge.
    cfg_send(0, 32);
    n = 0;
    do begin
      step();
      n++;
    end while (!cfg_ready && n < 20);
    chk("apply_on_carry", ce[0], 1);
    count_to_ce(0, n);
    chk("ce0_period32", n, 8);

    // Out-of-range channel is dropped after one cycle.
    cfg_send(3, 5);
    step();
    chk("discard_ready", cfg_ready, 1);
    repeat (10) step();

    // Lock loss while running.
    locked = 1'b0;
    repeat (3) step();
    chk("drop_rst", rst_out, 1);
    chk("drop_ce", ce, 0);
    chk("drop_lost", lock_lost, MON);
    chk("drop_cnt", lost_cnt, MON ? 1 : 0);
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    chk("clr_lost", lock_lost, 0);

    // One-cycle glitch during stabilisation restarts the count.
    locked = 1'b1;
    repeat (4) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    count_to_run(n);
    chk("restab_edges", n, LC + 3);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 63) == 0) locked = ~locked;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: cfg_inc = 8'd0;
        1: cfg_inc = 8'd32;
        2: cfg_inc = 8'd64;
        3: cfg_inc = 8'd128;
        default: cfg_inc = 8'($urandom_range(0, 255));
      endcase
      lost_clr = ($urandom_range(0, 99) == 0);
      step();
    end
    cfg_valid = 1'b0;
    lost_clr = 1'b0;

    // Reset while an update is pending must discard it.
    locked = 1'b1;
    count_to_run(n);
    cfg_send(0, 16);
    do_reset();
    count_to_run(n);
    chk("post_reset_edges", n, LC + 3);
    repeat (12) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
